// File: rtl/vs_ram_arbiter.sv
// vs_ram_arbiter: grants one requester exclusive use of the var-states BRAM, then drains its late writes.
// Define VS_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module vs_ram_arbiter #(
    parameter int NUM_REQ               = 3,
    parameter int ADDR_WIDTH_VAR_STATES = 9,
    parameter int WIDTH_VAR_STATES      = 30,
    parameter int DRAIN_CYC             = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_i,
    output logic [NUM_REQ-1:0]                      gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH_VAR_STATES-1:0] req_raddr_i,
    input  logic [NUM_REQ-1:0]                      req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH_VAR_STATES-1:0] req_waddr_i,
    input  logic [NUM_REQ*WIDTH_VAR_STATES-1:0]      req_wdata_i,
    output logic [WIDTH_VAR_STATES-1:0]             rdata_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]        ram_raddr_o,
    input  logic [WIDTH_VAR_STATES-1:0]             ram_rdata_i,
    output logic                                    ram_we_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]        ram_waddr_o,
    output logic [WIDTH_VAR_STATES-1:0]             ram_wdata_o,
    output logic                                    busy_o,
    output logic                                    err_o
);
    localparam int AW = ADDR_WIDTH_VAR_STATES;
    localparam int DW = WIDTH_VAR_STATES;
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t             state, state_nx;
    logic [OW-1:0]      owner, owner_nx, winner, start;
    logic [3:0]         drain_cnt, drain_nx;
    logic [NUM_REQ-1:0] gnt_nx, own_hot, rot;
    logic [AW-1:0]      raddr_nx, waddr_nx;
    logic [DW-1:0]      wdata_nx;
    logic               we_nx, err_nx, found;
    logic [AW-1:0]      raddr_a [NUM_REQ];
    logic [AW-1:0]      waddr_a [NUM_REQ];
    logic [DW-1:0]      wdata_a [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign raddr_a[k] = req_raddr_i[k*AW +: AW];
        assign waddr_a[k] = req_waddr_i[k*AW +: AW];
        assign wdata_a[k] = req_wdata_i[k*DW +: DW];
    end

`ifdef VS_ARB_RR_EN
    logic [OW-1:0]        last_owner;
    logic [2*NUM_REQ-1:0] dbl;
    // Rotate requests so the search begins just after the previous owner.
    assign start = (int'(last_owner) == NUM_REQ - 1) ? '0 : last_owner + 1'b1;
    assign dbl   = {req_i, req_i} >> start;
    assign rot   = dbl[NUM_REQ-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_owner <= OW'(NUM_REQ - 1);
        else if (state == IDLE && found) last_owner <= winner;
    end
`else
    assign start = '0;
    assign rot   = req_i;
`endif

    assign found   = |rot;
    assign own_hot = NUM_REQ'(1) << owner;
    assign rdata_o = ram_rdata_i;
    assign busy_o  = state != IDLE;

    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) winner = OW'((int'(start) + i) % NUM_REQ);
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        drain_nx = drain_cnt;
        gnt_nx   = '0;
        raddr_nx = '0;
        we_nx    = 1'b0;
        waddr_nx = '0;
        wdata_nx = '0;
        err_nx   = err_o | (state != IDLE && |(req_we_i & ~own_hot));
        case (state)
            IDLE: if (found) begin
                state_nx = GRANT;
                owner_nx = winner;
                gnt_nx   = NUM_REQ'(1) << winner;
                raddr_nx = raddr_a[winner];
            end
            GRANT: if (req_i[owner]) begin
                gnt_nx   = own_hot;
                raddr_nx = raddr_a[owner];
                we_nx    = req_we_i[owner];
                waddr_nx = waddr_a[owner];
                wdata_nx = wdata_a[owner];
            end else if (DRAIN_CYC == 0) begin
                state_nx = IDLE;
            end else begin
                state_nx = DRAIN;
                drain_nx = 4'(DRAIN_CYC);
                we_nx    = req_we_i[owner];
                waddr_nx = waddr_a[owner];
                wdata_nx = wdata_a[owner];
            end
            DRAIN: if (drain_cnt <= 4'd1) begin
                state_nx = IDLE;
                drain_nx = '0;
            end else begin
                drain_nx = drain_cnt - 4'd1;
                we_nx    = req_we_i[owner];
                waddr_nx = waddr_a[owner];
                wdata_nx = wdata_a[owner];
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            drain_cnt   <= '0;
            gnt_o       <= '0;
            ram_raddr_o <= '0;
            ram_we_o    <= 1'b0;
            ram_waddr_o <= '0;
            ram_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            drain_cnt   <= drain_nx;
            gnt_o       <= gnt_nx;
            ram_raddr_o <= raddr_nx;
            ram_we_o    <= we_nx;
            ram_waddr_o <= waddr_nx;
            ram_wdata_o <= wdata_nx;
            err_o       <= err_nx;
        end
    end
endmodule

// File: tb/tb_vs_ram_arbiter.sv
// tb_vs_ram_arbiter: two arbiters (drain 2 and drain 0) on shared stimulus, checked against a transaction-level model.
module tb_vs_ram_arbiter;
    logic        clk = 1'b0, rst = 1'b1, pre = 1'b1;
    logic [2:0]  req = '0, we_v = '0;
    logic [8:0]  ra [3], wa [3];
    logic [29:0] wd [3];
    logic [26:0] req_raddr, req_waddr;
    logic [89:0] req_wdata;
    logic [2:0]  gnt [2];
    logic [8:0]  rra [2], rwa [2];
    logic [29:0] rwd [2], rrd [2], rdata [2];
    logic        rwe [2], busy [2], err [2];
    logic [29:0] mem [2][512];
    int          checks = 0, errors = 0;

    typedef struct {
        int          own, left, last;
        bit          held, err;
        logic [2:0]  gnt;
        logic [8:0]  raddr, waddr;
        logic        we;
        logic [29:0] wdata;
    } mst_t;
    localparam int DRN [2] = '{2, 0};
    mst_t m [2];

    assign req_raddr = {ra[2], ra[1], ra[0]};
    assign req_waddr = {wa[2], wa[1], wa[0]};
    assign req_wdata = {wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    vs_ram_arbiter #(.DRAIN_CYC(2)) u0 (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt[0]), .req_raddr_i(req_raddr),
        .req_we_i(we_v), .req_waddr_i(req_waddr), .req_wdata_i(req_wdata), .rdata_o(rdata[0]),
        .ram_raddr_o(rra[0]), .ram_rdata_i(rrd[0]), .ram_we_o(rwe[0]), .ram_waddr_o(rwa[0]),
        .ram_wdata_o(rwd[0]), .busy_o(busy[0]), .err_o(err[0]));
    vs_ram_arbiter #(.DRAIN_CYC(0)) u1 (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt[1]), .req_raddr_i(req_raddr),
        .req_we_i(we_v), .req_waddr_i(req_waddr), .req_wdata_i(req_wdata), .rdata_o(rdata[1]),
        .ram_raddr_o(rra[1]), .ram_rdata_i(rrd[1]), .ram_we_o(rwe[1]), .ram_waddr_o(rwa[1]),
        .ram_wdata_o(rwd[1]), .busy_o(busy[1]), .err_o(err[1]));

    function automatic logic [29:0] init_val(input int a);
        return 30'(a * 3 + 1);
    endfunction

    // Synchronous-read BRAM, one per arbiter.
    always @(posedge clk)
        for (int d = 0; d < 2; d++) begin
            if (pre) for (int a = 0; a < 512; a++) mem[d][a] <= init_val(a);
            else if (rwe[d]) mem[d][rwa[d]] <= rwd[d];
            rrd[d] <= mem[d][rra[d]];
        end

    function automatic int pick(input logic [2:0] r, input int last);
        for (int i = 1; i <= 3; i++) if (r[(last + i) % 3]) return (last + i) % 3;
        return -1;
    endfunction

    // One model step: expected registered outputs after this clock edge.
    function automatic mst_t step(input mst_t s, input int drn);
        mst_t n = s;
        int w;
        n.gnt = '0; n.raddr = '0; n.we = 1'b0; n.waddr = '0; n.wdata = '0;
        if (s.own >= 0) for (int k = 0; k < 3; k++) if (k != s.own && we_v[k]) n.err = 1'b1;
        if (s.own < 0) begin
            w = pick(req, s.last);
            if (w >= 0) begin
                n.own = w; n.held = 1'b1; n.gnt = 3'(1 << w); n.raddr = ra[w];
`ifdef VS_ARB_RR_EN
                n.last = w;
`endif
            end
        end else if (s.held && req[s.own]) begin
            n.gnt = 3'(1 << s.own); n.raddr = ra[s.own];
            n.we = we_v[s.own]; n.waddr = wa[s.own]; n.wdata = wd[s.own];
        end else begin
            n.held = 1'b0;
            n.left = s.held ? drn : s.left;
            if (n.left > 0) begin
                n.we = we_v[s.own]; n.waddr = wa[s.own]; n.wdata = wd[s.own];
                n.left--;
            end else n.own = -1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        for (int d = 0; d < 2; d++)
            m[d] <= rst ? '{own: -1, left: 0, last: 2, held: 1'b0, err: 1'b0, gnt: '0,
                            raddr: '0, waddr: '0, we: 1'b0, wdata: '0}
                        : step(m[d], DRN[d]);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && !pre)
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d gnt", d), 32'(gnt[d]), 32'(m[d].gnt));
                chk($sformatf("d%0d raddr", d), 32'(rra[d]), 32'(m[d].raddr));
                chk($sformatf("d%0d we", d), 32'(rwe[d]), 32'(m[d].we));
                chk($sformatf("d%0d waddr", d), 32'(rwa[d]), 32'(m[d].waddr));
                chk($sformatf("d%0d wdata", d), 32'(rwd[d]), 32'(m[d].wdata));
                chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m[d].own >= 0));
                chk($sformatf("d%0d err", d), 32'(err[d]), 32'(m[d].err));
                chk($sformatf("d%0d rdata", d), 32'(rdata[d]), 32'(rrd[d]));
            end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_seq [3];
        logic [2:0] g;
        for (int k = 0; k < 3; k++) begin ra[k] = '0; wa[k] = '0; wd[k] = '0; end
        cyc(2);
        pre = 1'b0;
        cyc();
        rst = 1'b0;
        chk("reset gnt", 32'(gnt[0]), 32'h0);
        chk("reset busy", 32'(busy[0]), 32'h0);
        cyc();
        // Requester 1 alone, read address 5.
        req = 3'b010; ra[1] = 9'd5;
        cyc();
        chk("r1 gnt", 32'(gnt[0]), 32'h2);
        chk("r1 raddr", 32'(rra[0]), 32'd5);
        cyc();
        chk("r1 rdata", 32'(rdata[0]), 32'd16);
        // Non-owner 0 writes (error), owner 1 writes addr 20.
        we_v = 3'b011; wa[0] = 9'd9; wd[0] = 30'h3ff; wa[1] = 9'd20; wd[1] = 30'h2aa;
        cyc();
        chk("err set", 32'(err[0]), 32'h1);
        chk("owner we", 32'(rwe[0]), 32'h1);
        chk("owner waddr", 32'(rwa[0]), 32'd20);
        we_v = '0; req = '0;
        cyc(5);
        chk("err sticky", 32'(err[0]), 32'h1);
        chk("mem9 kept", 32'(mem[0][9]), 32'd28);
        chk("mem20 written", 32'(mem[0][20]), 32'h2aa);
        // Asynchronous reset while requester 0 owns and is writing.
        req = 3'b001; we_v = 3'b001; wa[0] = 9'd33; wd[0] = 30'h111;
        cyc(2);
        chk("pre-rst we", 32'(rwe[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst gnt", 32'(gnt[0]), 32'h0);
        chk("arst we", 32'(rwe[0]), 32'h0);
        chk("arst busy", 32'(busy[0]), 32'h0);
        chk("arst err", 32'(err[0]), 32'h0);
        chk("arst err d1", 32'(err[1]), 32'h0);
        cyc();
        rst = 1'b0; req = '0; we_v = '0;
        cyc(2);
        chk("mem33 kept", 32'(mem[0][33]), 32'd100);
        // Drain window: owner 2 writes on its release cycle and the next.
        req = 3'b100;
        cyc(2);
        req = 3'b000; we_v = 3'b100; wa[2] = 9'd7; wd[2] = 30'h155;
        cyc();
        chk("drain0 we", 32'(rwe[0]), 32'h1);
        chk("drain0 waddr", 32'(rwa[0]), 32'd7);
        chk("drain0 wdata", 32'(rwd[0]), 32'h155);
        chk("drain0 gnt", 32'(gnt[0]), 32'h0);
        chk("nodrain we", 32'(rwe[1]), 32'h0);
        chk("nodrain busy", 32'(busy[1]), 32'h0);
        req = 3'b100;
        cyc();
        chk("drain1 we", 32'(rwe[0]), 32'h1);
        chk("drain1 busy", 32'(busy[0]), 32'h1);
        chk("nodrain regrant", 32'(gnt[1]), 32'h4);
        we_v = '0;
        cyc();
        chk("drain idle gnt", 32'(gnt[0]), 32'h0);
        chk("drain idle busy", 32'(busy[0]), 32'h0);
        cyc();
        chk("drain regrant", 32'(gnt[0]), 32'h4);
        req = '0;
        cyc(4);
        chk("mem7 drained", 32'(mem[0][7]), 32'h155);
        chk("mem7 no drain", 32'(mem[1][7]), 32'd22);
        // All three request; each owner holds three cycles then releases once.
`ifdef VS_ARB_RR_EN
        exp_seq = '{0, 1, 2};
`else
        exp_seq = '{0, 0, 0};
`endif
        for (int r = 0; r < 3; r++) begin
            req = 3'b111;
            for (int n = 0; n < 20 && gnt[0] == 3'b000; n++) cyc();
            chk($sformatf("arb%0d granted", r), 32'(gnt[0] != 3'b000), 32'h1);
            g = gnt[0];
            chk($sformatf("arb%0d owner", r), 32'(g), 32'(1 << exp_seq[r]));
            cyc(2);
            req = 3'b111 & ~g;
            cyc();
        end
        req = '0;
        cyc(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vs_ram_arbiter.md
Name: vs_ram_arbiter

Overview:
- Shares the single var-states BRAM (one read port, one write port) between NUM_REQ bin-manager requesters, such as bin load, bin update and cross-bin backtrack.
- A requester gains exclusive ownership of both ports and keeps it until it releases.
- The arbiter then holds the released owner's write path open for a drain window, so its delayed pipeline writes still land.
- Sits between the bin-manager sub-blocks and the var-states BRAM; it replaces ad-hoc apply_* muxing.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is highest fixed priority.
- ADDR_WIDTH_VAR_STATES, 9, BRAM address width.
- WIDTH_VAR_STATES, 30, BRAM data width.
- DRAIN_CYC, 2, cycles the released owner's write port stays forwarded; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request/hold; high = want or keep ownership.
- gnt_o  out  NUM_REQ  one-hot grant, registered.
- req_raddr_i  in  NUM_REQ*ADDR_WIDTH_VAR_STATES  packed read addresses; requester k in slice k.
- req_we_i  in  NUM_REQ  write enables.
- req_waddr_i  in  NUM_REQ*ADDR_WIDTH_VAR_STATES  packed write addresses.
- req_wdata_i  in  NUM_REQ*WIDTH_VAR_STATES  packed write data.
- rdata_o  out  WIDTH_VAR_STATES  BRAM read data, broadcast to all requesters.
- ram_raddr_o  out  ADDR_WIDTH_VAR_STATES  to BRAM, registered.
- ram_rdata_i  in  WIDTH_VAR_STATES  from BRAM.
- ram_we_o  out  1  to BRAM, registered.
- ram_waddr_o  out  ADDR_WIDTH_VAR_STATES  to BRAM, registered.
- ram_wdata_o  out  WIDTH_VAR_STATES  to BRAM, registered.
- busy_o  out  1  high whenever state is not IDLE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=0, drain_cnt=0. All outputs 0: gnt_o, ram_*_o, busy_o, err_o. Any in-flight write is dropped. Reset deassertion takes effect on the next clk edge.
- rdata_o = ram_rdata_i, combinational.
- Read latency seen by the owner: address driven in cycle t reaches BRAM at t+1; data is valid on rdata_o at t+2.
- State IDLE:
  - If req_i != 0, pick a winner (fixed priority: lowest index). Next cycle: owner=winner, gnt_o=onehot(winner), state=GRANT.
  - ram_we_o=0 and ram_raddr_o=0 while IDLE.
- State GRANT:
  - ram_raddr_o, ram_we_o, ram_waddr_o and ram_wdata_o are registered copies of the owner's slices.
  - Other requesters' inputs are ignored.
  - If req_i[owner]=0: gnt_o clears next cycle. Then state=DRAIN with drain_cnt=DRAIN_CYC, or state=IDLE if DRAIN_CYC=0.
- State DRAIN:
  - The owner's write port is still forwarded. ram_raddr_o is forced to 0.
  - drain_cnt decrements each cycle; at 1, next state=IDLE.
  - Requests (including the old owner's re-request) wait; they are arbitrated in IDLE.
- Turnaround: minimum release-to-next-grant gap is DRAIN_CYC+2 cycles.
- Simultaneous requests in IDLE: exactly one grant; losers keep req high and are served later in priority order.
- Requests that drop before being granted are silently forgotten.
- Writes from non-owners never reach BRAM.
- err_o is set sticky when req_we_i[k]=1 while k is not the owner in GRANT/DRAIN. The offending write is discarded. err_o clears only on rst.
- gnt_o is always one-hot or zero; it is never high outside GRANT.

Optional Feature:
- Macro: VS_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last_owner+1) mod NUM_REQ, and last_owner updates on every grant. Reset value of last_owner = NUM_REQ-1, so the first search starts at index 0.
- Not defined: fixed priority, index 0 highest; no last_owner register is synthesized.

Test Plan:
- Reset mid-GRANT with req_we_i[0]=1: raise rst → gnt_o=0, ram_we_o=0, busy_o=0, err_o=0 immediately without waiting for clk; no BRAM write occurs.
- Requester 1 alone: req_i=3'b010, raddr=5 at cycle t → gnt_o=3'b010 one cycle later; ram_raddr_o=5 at t+1; rdata_o shows mem[5] at t+2.
- Drain window (DRAIN_CYC=2): owner 2 drops req and writes addr 7 data 0x155 on the release cycle and the next cycle → both writes appear on ram_we_o/ram_waddr_o; gnt_o=0; next grant no earlier than 4 cycles after release.
- req_i=3'b111 held continuously, each owner holding for 3 cycles before releasing. Fixed priority: grants 0,0,0,… with repeated requests from 0. With VS_ARB_RR_EN and each requester releasing and re-requesting: grants 0,1,2,0.
- Requester 0 asserts req_we_i while owner is 1 → err_o=1 stays high; BRAM contents at its address unchanged; owner 1 traffic unaffected.
- DRAIN_CYC=0: release → IDLE next cycle; a pending req_i[2] is granted one cycle after that.
